sad_min_select: RTL and testbench

//  Downstream of the 32x32 PE array. Consumes its per-beat absolute-difference

---
 rtl/sad_pkg.sv | 33 +++
 rtl/sad_8x8_tree.sv | 53 +++++
 rtl/sad_min_select.sv | 198 +++++++++++++++++++
 tb/tb_sad_min_select.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// Shared constants and types for the SAD minimum-select datapath.
// Widths are sized so that every adder stage is lossless for 8-bit samples:
//   row segment (8 samples)  : 11 b
//   8x8 block SAD            : 14 b
//   16x16 quadrant SAD       : 16 b
//   32x32 block SAD          : 18 b
package sad_pkg;

    localparam int ARR_DIM   = 32;
    localparam int N_BLK8    = 16;   // 8x8 blocks in the 32x32 array
    localparam int SEG_W     = 11;
    localparam int SAD8_W    = 14;
    localparam int SAD16_W   = 16;
    localparam int SAD32_W   = 18;

    // "Worse than anything reachable" start values; the largest real SADs
    // (65280 / 261120) are strictly below these, so the first beat always wins.
    localparam logic [SAD16_W-1:0] SAD16_INIT = '1;
    localparam logic [SAD32_W-1:0] SAD32_INIT = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // 8x8 blocks are numbered row-major: blk = 4*block_row + block_col.
    // Quadrant q = 2*(block_row/2) + (block_col/2).
    function automatic logic [1:0] quad_of_blk(input int blk);
        return 2'(2 * ((blk / 4) / 2) + ((blk % 4) / 2));
    endfunction

endpackage

// File: rtl/sad_8x8_tree.sv
// One 8x8 window reduced to its sum of absolute differences.
// Two register stages: eight row-segment sums (S1), then the block sum (S2).
// Data registers carry no reset; validity is tracked by the parent.
// Ports:
//   clk   rising-edge clock
//   win   64 samples, sample (r,c) at [(8*r+c)*PIXEL +: PIXEL]
//   sad8  registered 8x8 SAD (S2 output)
module sad_8x8_tree
    import sad_pkg::*;
#(
    parameter int PIXEL = 8
) (
    input  logic                  clk,
    input  logic [64*PIXEL-1:0]   win,
    output logic [SAD8_W-1:0]     sad8
);

    logic [SEG_W-1:0]  seg_next [8];
    logic [SEG_W-1:0]  seg_reg  [8];
    logic [SAD8_W-1:0] sad8_next;
    logic [SAD8_W-1:0] sad8_reg;

    function automatic logic [SEG_W-1:0] row_sum(input logic [8*PIXEL-1:0] row);
        logic [SEG_W-1:0] acc;
        acc = '0;
        for (int c = 0; c < 8; c++) begin
            acc = acc + SEG_W'(row[c*PIXEL +: PIXEL]);
        end
        return acc;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_row
            assign seg_next[gi] = row_sum(win[8*gi*PIXEL +: 8*PIXEL]);
        end
    endgenerate

    always_comb begin
        sad8_next = '0;
        for (int r = 0; r < 8; r++) begin
            sad8_next = sad8_next + SAD8_W'(seg_reg[r]);
        end
    end

    always_ff @(posedge clk) begin
        seg_reg  <= seg_next;
        sad8_reg <= sad8_next;
    end

    assign sad8 = sad8_reg;

endmodule

// File: rtl/sad_min_select.sv
// Reduces each accepted absolute-difference plane to four 16x16 quadrant SADs
// and one 32x32 SAD, and keeps the minimum of each (with its MV) over a
// search window framed by search_start / abs_last, ending with a done pulse.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   search_start             clear bests and (re)start a window (also aborts)
//   abs_valid, abs_last      beat strobe / final-beat qualifier
//   abs_outs                 1024 samples, (r,c) at [(32*r+c)*PIXEL +: PIXEL]
//   mv_x, mv_y               candidate MV of the beat
//   busy                     window in progress (SEARCH or DRAIN)
//   done                     one-cycle pulse, best_* final for the window
//   best_sad16/mv16_x/mv16_y per-quadrant winners, quadrant q at slice q
//   best_sad32/mv32_x/mv32_y whole-block winner
// Pipeline: S1/S2 inside the 8x8 trees, S3 here; winners update on the edge
// ending the S3 cycle, so a beat at t is reflected (and done raised) in t+4.
module sad_min_select
    import sad_pkg::*;
#(
    parameter int PIXEL = 8,
    parameter int MV_W  = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     search_start,
    input  logic                     abs_valid,
    input  logic                     abs_last,
    input  logic [1024*PIXEL-1:0]    abs_outs,
    input  logic [MV_W-1:0]          mv_x,
    input  logic [MV_W-1:0]          mv_y,
    output logic                     busy,
    output logic                     done,
    output logic [4*SAD16_W-1:0]     best_sad16,
    output logic [4*MV_W-1:0]        best_mv16_x,
    output logic [4*MV_W-1:0]        best_mv16_y,
    output logic [SAD32_W-1:0]       best_sad32,
    output logic [MV_W-1:0]          best_mv32_x,
    output logic [MV_W-1:0]          best_mv32_y
);

    // ------------------------------------------------------------------
    // S1/S2: sixteen 8x8 trees
    // ------------------------------------------------------------------
    logic [SAD8_W-1:0] sad8 [N_BLK8];

    genvar gi, gr, gc;
    generate
        for (gi = 0; gi < N_BLK8; gi++) begin : g_blk
            localparam int BR = gi / 4;
            localparam int BC = gi % 4;
            logic [64*PIXEL-1:0] win;
            for (gr = 0; gr < 8; gr++) begin : g_r
                for (gc = 0; gc < 8; gc++) begin : g_c
                    assign win[(8*gr+gc)*PIXEL +: PIXEL] =
                        abs_outs[(ARR_DIM*(8*BR+gr) + 8*BC + gc)*PIXEL +: PIXEL];
                end
            end
            sad_8x8_tree #(.PIXEL(PIXEL)) u_tree (
                .clk  (clk),
                .win  (win),
                .sad8 (sad8[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // S3: quadrant and whole-block sums straight from the S2 registers
    // ------------------------------------------------------------------
    logic [SAD16_W-1:0] sad16_next [4];
    logic [SAD32_W-1:0] sad32_next;
    logic [SAD16_W-1:0] sad16_reg  [4];
    logic [SAD32_W-1:0] sad32_reg;

    always_comb begin
        for (int q = 0; q < 4; q++) begin
            sad16_next[q] = '0;
        end
        sad32_next = '0;
        for (int b = 0; b < N_BLK8; b++) begin
            sad16_next[quad_of_blk(b)] = sad16_next[quad_of_blk(b)] + SAD16_W'(sad8[b]);
            sad32_next = sad32_next + SAD32_W'(sad8[b]);
        end
    end

    // Tag pipe: index 2 lines up with sad*_reg (all three stages deep).
    logic [MV_W-1:0] mvx_pipe [3];
    logic [MV_W-1:0] mvy_pipe [3];
    logic [2:0]      last_pipe;

    always_ff @(posedge clk) begin
        sad16_reg   <= sad16_next;
        sad32_reg   <= sad32_next;
        mvx_pipe[0] <= mv_x;
        mvx_pipe[1] <= mvx_pipe[0];
        mvx_pipe[2] <= mvx_pipe[1];
        mvy_pipe[0] <= mv_y;
        mvy_pipe[1] <= mvy_pipe[0];
        mvy_pipe[2] <= mvy_pipe[1];
        last_pipe   <= {last_pipe[1:0], abs_last};
    end

    // ------------------------------------------------------------------
    // FSM, valid pipe and winner registers
    // ------------------------------------------------------------------
    state_t             state_reg;
    logic [2:0]         valid_reg;     // [0]=S1, [1]=S2, [2]=S3
    logic               done_reg;
    logic [SAD16_W-1:0] best16_reg [4];
    logic [MV_W-1:0]    bmx16_reg  [4];
    logic [MV_W-1:0]    bmy16_reg  [4];
    logic [SAD32_W-1:0] best32_reg;
    logic [MV_W-1:0]    bmx32_reg;
    logic [MV_W-1:0]    bmy32_reg;
    logic               accept;

    // search_start opens a window even from IDLE/DRAIN, so a coincident beat
    // becomes beat 0 of the new window.
    assign accept = abs_valid && (search_start || (state_reg == SEARCH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            valid_reg  <= '0;
            done_reg   <= 1'b0;
            for (int q = 0; q < 4; q++) begin
                best16_reg[q] <= SAD16_INIT;
                bmx16_reg[q]  <= '0;
                bmy16_reg[q]  <= '0;
            end
            best32_reg <= SAD32_INIT;
            bmx32_reg  <= '0;
            bmy32_reg  <= '0;
        end else begin
            done_reg <= 1'b0;
            if (search_start) begin
                // New window or abort: flush in-flight beats, suppress the
                // S3 compare this edge, no done.
                valid_reg <= {2'b00, accept};
                state_reg <= (abs_valid && abs_last) ? DRAIN : SEARCH;
                for (int q = 0; q < 4; q++) begin
                    best16_reg[q] <= SAD16_INIT;
                    bmx16_reg[q]  <= '0;
                    bmy16_reg[q]  <= '0;
                end
                best32_reg <= SAD32_INIT;
                bmx32_reg  <= '0;
                bmy32_reg  <= '0;
            end else begin
                valid_reg <= {valid_reg[1:0], accept};
                // Strict less-than: ties keep the earlier MV.
                if (valid_reg[2]) begin
                    for (int q = 0; q < 4; q++) begin
                        if (sad16_reg[q] < best16_reg[q]) begin
                            best16_reg[q] <= sad16_reg[q];
                            bmx16_reg[q]  <= mvx_pipe[2];
                            bmy16_reg[q]  <= mvy_pipe[2];
                        end
                    end
                    if (sad32_reg < best32_reg) begin
                        best32_reg <= sad32_reg;
                        bmx32_reg  <= mvx_pipe[2];
                        bmy32_reg  <= mvy_pipe[2];
                    end
                end
                case (state_reg)
                    SEARCH: begin
                        if (abs_valid && abs_last) begin
                            state_reg <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (valid_reg[2] && last_pipe[2]) begin
                            state_reg <= IDLE;
                            done_reg  <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign busy        = (state_reg != IDLE);
    assign done        = done_reg;
    assign best_sad32  = best32_reg;
    assign best_mv32_x = bmx32_reg;
    assign best_mv32_y = bmy32_reg;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_out
            assign best_sad16 [SAD16_W*gi +: SAD16_W] = best16_reg[gi];
            assign best_mv16_x[MV_W*gi    +: MV_W]    = bmx16_reg[gi];
            assign best_mv16_y[MV_W*gi    +: MV_W]    = bmy16_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_sad_min_select.sv
module tb_sad_min_select;

    localparam int PIXEL = 8;
    localparam int MV_W  = 7;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  search_start;
    logic                  abs_valid;
    logic                  abs_last;
    logic [1024*PIXEL-1:0] abs_outs;
    logic [MV_W-1:0]       mv_x;
    logic [MV_W-1:0]       mv_y;
    logic                  busy;
    logic                  done;
    logic [63:0]           best_sad16;
    logic [4*MV_W-1:0]     best_mv16_x;
    logic [4*MV_W-1:0]     best_mv16_y;
    logic [17:0]           best_sad32;
    logic [MV_W-1:0]       best_mv32_x;
    logic [MV_W-1:0]       best_mv32_y;

    sad_min_select #(.PIXEL(PIXEL), .MV_W(MV_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .search_start (search_start),
        .abs_valid    (abs_valid),
        .abs_last     (abs_last),
        .abs_outs     (abs_outs),
        .mv_x         (mv_x),
        .mv_y         (mv_y),
        .busy         (busy),
        .done         (done),
        .best_sad16   (best_sad16),
        .best_mv16_x  (best_mv16_x),
        .best_mv16_y  (best_mv16_y),
        .best_sad32   (best_sad32),
        .best_mv32_x  (best_mv32_x),
        .best_mv32_y  (best_mv32_y)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a window is a list of beats; each beat's SADs are
    // plain sums over the plane, applied three edges after acceptance.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [3:0][15:0] s16;
        logic [17:0]      s32;
        logic [6:0]       mx;
        logic [6:0]       my;
        logic             last;
        int               due;
    } beat_t;

    beat_t       pipe_q[$];
    beat_t       m_beat;
    int          m_phase = 0;        // 0 no window, 1 taking beats, 2 waiting for last
    logic        m_done  = 1'b0;
    logic [15:0] m_b16  [4];
    logic [6:0]  m_bx16 [4];
    logic [6:0]  m_by16 [4];
    logic [17:0] m_b32;
    logic [6:0]  m_bx32;
    logic [6:0]  m_by32;
    int          mcyc = 0;

    task automatic clear_best();
        for (int q = 0; q < 4; q++) begin
            m_b16[q]  = 16'hFFFF;
            m_bx16[q] = '0;
            m_by16[q] = '0;
        end
        m_b32  = 18'h3FFFF;
        m_bx32 = '0;
        m_by32 = '0;
    endtask

    function automatic beat_t make_beat(input int due);
        beat_t b;
        int    acc16 [4];
        int    acc32;
        for (int q = 0; q < 4; q++) acc16[q] = 0;
        acc32 = 0;
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 32; c++) begin
                int v;
                v = int'(abs_outs[(32*r+c)*PIXEL +: PIXEL]);
                acc16[(r/16)*2 + c/16] += v;
                acc32 += v;
            end
        end
        for (int q = 0; q < 4; q++) b.s16[q] = acc16[q][15:0];
        b.s32  = acc32[17:0];
        b.mx   = mv_x;
        b.my   = mv_y;
        b.last = abs_last;
        b.due  = due;
        return b;
    endfunction

    initial clear_best();

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q.delete();
            m_phase = 0;
            m_done  = 1'b0;
            clear_best();
        end else begin
            m_done = 1'b0;
            if (search_start) begin
                pipe_q.delete();
                clear_best();
                if (abs_valid) pipe_q.push_back(make_beat(mcyc + 3));
                m_phase = (abs_valid && abs_last) ? 2 : 1;
            end else begin
                while (pipe_q.size() > 0 && pipe_q[0].due == mcyc) begin
                    m_beat = pipe_q.pop_front();
                    for (int q = 0; q < 4; q++) begin
                        if (m_beat.s16[q] < m_b16[q]) begin
                            m_b16[q]  = m_beat.s16[q];
                            m_bx16[q] = m_beat.mx;
                            m_by16[q] = m_beat.my;
                        end
                    end
                    if (m_beat.s32 < m_b32) begin
                        m_b32  = m_beat.s32;
                        m_bx32 = m_beat.mx;
                        m_by32 = m_beat.my;
                    end
                    if (m_beat.last) begin
                        m_done  = 1'b1;
                        m_phase = 0;
                    end
                end
                if (m_phase == 1 && abs_valid) begin
                    pipe_q.push_back(make_beat(mcyc + 3));
                    if (abs_last) m_phase = 2;
                end
            end
            mcyc++;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("busy", 64'(busy), 64'(m_phase != 0));
            chk("done", 64'(done), 64'(m_done));
            for (int q = 0; q < 4; q++) begin
                chk("sad16", 64'(best_sad16[16*q +: 16]), 64'(m_b16[q]));
                chk("mv16_x", 64'(best_mv16_x[MV_W*q +: MV_W]), 64'(m_bx16[q]));
                chk("mv16_y", 64'(best_mv16_y[MV_W*q +: MV_W]), 64'(m_by16[q]));
            end
            chk("sad32", 64'(best_sad32), 64'(m_b32));
            chk("mv32_x", 64'(best_mv32_x), 64'(m_bx32));
            chk("mv32_y", 64'(best_mv32_y), 64'(m_by32));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_all(input int v);
        logic [7:0] b;
        b = v[7:0];
        for (int i = 0; i < 1024; i++) abs_outs[i*PIXEL +: PIXEL] = b;
    endtask

    task automatic set_quad_zero(input int k);
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 32; c++) begin
                abs_outs[(32*r+c)*PIXEL +: PIXEL] = (((r/16)*2 + c/16) == k) ? 8'd0 : 8'd255;
            end
        end
    endtask

    task automatic drive(input bit start, input bit valid, input bit last, input int mx, input int my);
        search_start = start;
        abs_valid    = valid;
        abs_last     = last;
        mv_x         = mx[6:0];
        mv_y         = my[6:0];
    endtask

    task automatic idle_inputs();
        search_start = 1'b0;
        abs_valid    = 1'b0;
        abs_last     = 1'b0;
    endtask

    // Called right after driving the last beat in cycle t0.
    task automatic wait_done(input int t0, input string name);
        int lat;
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 0) idle_inputs();
            if (done === 1'b1) begin
                lat = cyc - t0;
                break;
            end
        end
        chk(name, 64'(lat), 64'(4));
    endtask

    int t0;
    int d0;

    initial begin
        rst = 1'b1;
        idle_inputs();
        abs_outs = '0;
        mv_x = '0;
        mv_y = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_sad16", best_sad16, {4{16'hFFFF}});
        chk("reset_sad32", 64'(best_sad32), 64'(18'h3FFFF));
        rst = 1'b0;

        // 1: reset mid-SEARCH with two beats in flight
        @(negedge clk); set_all(7); drive(1, 1, 0, 4, 4);
        @(negedge clk); drive(0, 1, 0, 5, 5);
        @(negedge clk); idle_inputs(); rst = 1'b1;
        @(negedge clk);
        chk("t1_busy_in_rst", 64'(busy), 64'(0));
        chk("t1_sad32_in_rst", 64'(best_sad32), 64'(18'h3FFFF));
        chk("t1_sad16_in_rst", best_sad16, {4{16'hFFFF}});
        rst = 1'b0;
        d0 = done_cnt;
        repeat (8) @(negedge clk);
        chk("t1_no_stale_sad32", 64'(best_sad32), 64'(18'h3FFFF));
        chk("t1_no_done", 64'(done_cnt - d0), 64'(0));

        // 2: single beat of ones, mv (3,-2), start and last together
        @(negedge clk); set_all(1); drive(1, 1, 1, 3, -2); t0 = cyc;
        wait_done(t0, "t2_latency");
        chk("t2_sad16", best_sad16, {4{16'd256}});
        chk("t2_sad32", 64'(best_sad32), 64'(1024));
        chk("t2_mv16_x", 64'(best_mv16_x), 64'({4{7'd3}}));
        chk("t2_mv16_y", 64'(best_mv16_y), 64'({4{7'h7E}}));
        chk("t2_mv32", 64'({best_mv32_x, best_mv32_y}), 64'({7'd3, 7'h7E}));

        // 3: beats 5/2/2, tie on beat 3 keeps beat 2
        @(negedge clk); drive(1, 0, 0, 0, 0);
        @(negedge clk); set_all(5); drive(0, 1, 0, 0, 0);
        @(negedge clk); set_all(2); drive(0, 1, 0, 1, 1);
        @(negedge clk); set_all(2); drive(0, 1, 1, 2, 2); t0 = cyc;
        wait_done(t0, "t3_latency");
        chk("t3_sad32", 64'(best_sad32), 64'(2048));
        chk("t3_mv32", 64'({best_mv32_x, best_mv32_y}), 64'({7'd1, 7'd1}));
        chk("t3_sad16", best_sad16, {4{16'd512}});
        chk("t3_mv16_x", 64'(best_mv16_x), 64'({4{7'd1}}));

        // 4: per-quadrant winners
        @(negedge clk); drive(1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); set_quad_zero(k); drive(0, 1, k == 3, 10 + k, -20 - k);
        end
        t0 = cyc;
        wait_done(t0, "t4_latency");
        chk("t4_sad16", best_sad16, 64'd0);
        chk("t4_mv16_x", 64'(best_mv16_x), 64'({7'd13, 7'd12, 7'd11, 7'd10}));
        chk("t4_mv16_y", 64'(best_mv16_y), 64'({7'd105, 7'd106, 7'd107, 7'd108}));
        chk("t4_sad32", 64'(best_sad32), 64'(195840));
        chk("t4_mv32", 64'({best_mv32_x, best_mv32_y}), 64'({7'd10, 7'd108}));

        // 5: full-scale samples, extreme MV
        @(negedge clk); set_all(255); drive(1, 1, 1, -64, 63); t0 = cyc;
        wait_done(t0, "t5_latency");
        chk("t5_sad16", best_sad16, {4{16'd65280}});
        chk("t5_sad32", 64'(best_sad32), 64'(261120));
        chk("t5_mv32", 64'({best_mv32_x, best_mv32_y}), 64'({7'h40, 7'd63}));

        // 6: abort with two zero beats in flight, new single zero beat
        @(negedge clk); set_all(0); drive(1, 1, 0, 9, 9);
        @(negedge clk); drive(0, 1, 0, 9, 9);
        @(negedge clk); drive(1, 1, 1, 5, 5); t0 = cyc; d0 = done_cnt;
        wait_done(t0, "t6_latency");
        repeat (4) @(negedge clk);
        chk("t6_one_done", 64'(done_cnt - d0), 64'(1));
        chk("t6_sad32", 64'(best_sad32), 64'(0));
        chk("t6_mv32", 64'({best_mv32_x, best_mv32_y}), 64'({7'd5, 7'd5}));
        chk("t6_mv16_x", 64'(best_mv16_x), 64'({4{7'd5}}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
